button_conditioner: RTL and testbench

//   Multi-channel push-button front end; parametrised successor to the 3-tap debouncer.
//   Per channel: metastability synchroniser, polarity normalisation, counter-based

---
 rtl/button_conditioner.sv | 117 +++++++++++
 tb/tb_button_conditioner.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end. Each channel has a synchroniser, a polarity fix,
// a counter debounce, press/release strobes and a one-shot long-press strobe.
module button_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 50000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic lng
);
    localparam int             DW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic           IDLE  = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   s;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        s       = sync_q[SYNC_STAGES-1] ^ IDLE;
        dcnt_d  = '0;
        level_d = level_q;
        // any sample matching the current level restarts the count
        if (s != level_q) begin
            if (dcnt_q == DLAST) level_d = s;
            else                 dcnt_d  = dcnt_q + 1'b1;
        end
        press_d = level_d & ~level_q;
        rel_d   = ~level_d & level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{IDLE}};
            dcnt_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

    if (HOLD_CYCLES > 0) begin : g_hold
        localparam int            HW    = $clog2(HOLD_CYCLES + 1);
        localparam logic [HW-1:0] HMAX  = HW'(HOLD_CYCLES);
        localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
        logic [HW-1:0] hcnt_q, hcnt_d;

        always_comb begin
            hcnt_d = hcnt_q;
            if (!level_q || press_q) hcnt_d = '0;
            else if (hcnt_q != HMAX) hcnt_d = hcnt_q + 1'b1;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) hcnt_q <= '0;
            else     hcnt_q <= hcnt_d;
        end

        // decoded from flops only: fires in the cycle hcnt steps off HOLD-1, never again
        assign lng = level_q & ~press_q & (hcnt_q == HLAST);
    end else begin : g_no_hold
        assign lng = 1'b0;
    end
endmodule

module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 50000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);
    for (genvar c = 0; c < NUM_BTN; c++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[c]),
            .level(btn_level[c]),
            .press(btn_press[c]),
            .rel  (btn_release[c]),
            .lng  (btn_long[c])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high and an active-low instance driven with
// complementary pins, both checked against a history-window reference model.
module tb_button_conditioner;
    localparam int NB = 2, SYNC = 2, DEB = 8, HOLD = 32;

    logic clk = 1'b0, rst = 1'b1;
    logic [NB-1:0] raw_a = '0, raw_b;
    logic [NB-1:0] lvl_a, prs_a, rel_a, lng_a;
    logic [NB-1:0] lvl_b, prs_b, rel_b, lng_b;
    assign raw_b = ~raw_a;

    always #5 clk = ~clk;

    button_conditioner #(.NUM_BTN(NB), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                         .HOLD_CYCLES(HOLD), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst), .btn_raw(raw_a), .btn_level(lvl_a),
        .btn_press(prs_a), .btn_release(rel_a), .btn_long(lng_a));

    button_conditioner #(.NUM_BTN(NB), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                         .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .btn_raw(raw_b), .btn_level(lvl_b),
        .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b));

    int errors = 0, checks = 0;

    // reference model: pressed-view pin history per edge, level/flip bookkeeping
    logic [NB-1:0] hq[$];
    int            edge_n;
    logic [NB-1:0] ml, ep, er, el;
    int            lf[NB], lp[NB];
    logic [4*NB-1:0] exp_v, obs_a, obs_b;

    function automatic logic s_at(int e, int c);
        logic [NB-1:0] v;
        if (e - SYNC < 1) return 1'b0;
        v = hq[e-SYNC-1];
        return v[c];
    endfunction

    task automatic model_init();
        hq.delete();
        edge_n = 0;
        ml = '0; ep = '0; er = '0; el = '0;
        for (int c = 0; c < NB; c++) begin lf[c] = 0; lp[c] = -100000; end
    endtask

    task automatic tick(input logic [NB-1:0] r);
        logic flip;
        raw_a = r;
        @(posedge clk);
        edge_n++;
        hq.push_back(r);
        for (int c = 0; c < NB; c++) begin
            flip = 1'b0;
            if (edge_n - lf[c] >= DEB) begin
                flip = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (s_at(edge_n - k, c) == ml[c]) flip = 1'b0;
            end
            ep[c] = flip && !ml[c];
            er[c] = flip && ml[c];
            if (flip) begin
                ml[c] = ~ml[c];
                lf[c] = edge_n;
                if (ml[c]) lp[c] = edge_n;
            end
            el[c] = ml[c] && (lp[c] == lf[c]) && (edge_n == lp[c] + HOLD);
        end
        exp_v = {ml, ep, er, el};
        #1;
        obs_a = {lvl_a, prs_a, rel_a, lng_a};
        obs_b = {lvl_b, prs_b, rel_b, lng_b};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_init();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            raw_a = 2'($urandom);
            @(posedge clk); #1;
            if ({lvl_a, prs_a, rel_a, lng_a, lvl_b, prs_b, rel_b, lng_b} !== '0) begin
                errors++;
                $display("FAIL reset_hold got a=%h b=%h want 0", {lvl_a, prs_a, rel_a, lng_a},
                         {lvl_b, prs_b, rel_b, lng_b});
            end
            checks++;
        end
        raw_a = '0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick('0);
            if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
                errors++;
                $display("FAIL reset_idle edge %0d got a=%h b=%h want %h", edge_n, obs_a, obs_b, exp_v);
            end
            checks++;
        end
    endtask

    task automatic test_press();
        int pe = -1, np = 0;
        logic [3:0] ch1 = '0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tick(2'b01);
            if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
                errors++;
                $display("FAIL press edge %0d got a=%h b=%h want %h", edge_n, obs_a, obs_b, exp_v);
            end
            checks++;
            if (prs_a[0]) begin pe = edge_n; np++; end
            ch1 |= {lvl_a[1], prs_a[1], rel_a[1], lng_a[1]};
        end
        if (pe != SYNC + DEB || np != 1) begin
            errors++;
            $display("FAIL press_edge got edge %0d count %0d want edge %0d count 1", pe, np, SYNC + DEB);
        end
        checks++;
        if (ch1 !== 4'b0) begin
            errors++;
            $display("FAIL press_ch1_quiet got %b want 0000", ch1);
        end
        checks++;
    endtask

    task automatic test_bounce();
        int np = 0, st, pe = -1;
        logic pat [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 13 + 12; i++) begin
            tick({1'b0, (i < 13) ? pat[i] : 1'b0});
            if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
                errors++;
                $display("FAIL bounce edge %0d got a=%h b=%h want %h", edge_n, obs_a, obs_b, exp_v);
            end
            checks++;
            np += int'(prs_a[0] | rel_a[0] | lvl_a[0]);
        end
        if (np != 0) begin
            errors++;
            $display("FAIL bounce_quiet got %0d active cycles want 0", np);
        end
        checks++;
        st = edge_n;
        for (int i = 0; i < 12; i++) begin
            tick(2'b01);
            if (prs_a[0]) pe = edge_n - st;
        end
        if (pe != SYNC + DEB) begin
            errors++;
            $display("FAIL bounce_recount got press at %0d want %0d", pe, SYNC + DEB);
        end
        checks++;
    endtask

    task automatic test_long();
        int pe = -1, le = -1, nl = 0, re = -1, st;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            tick(2'b10);
            if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
                errors++;
                $display("FAIL long edge %0d got a=%h b=%h want %h", edge_n, obs_a, obs_b, exp_v);
            end
            checks++;
            if (prs_a[1]) pe = edge_n;
            if (lng_a[1]) begin le = edge_n; nl++; end
        end
        if (pe != SYNC + DEB || le - pe != HOLD || nl != 1) begin
            errors++;
            $display("FAIL long_timing got press %0d long %0d count %0d want press %0d long %0d count 1",
                     pe, le, nl, SYNC + DEB, SYNC + DEB + HOLD);
        end
        checks++;
        st = edge_n;
        for (int i = 0; i < 14; i++) begin
            tick(2'b00);
            if (rel_a[1] && rel_b[1]) re = edge_n - st;
        end
        if (re != SYNC + DEB) begin
            errors++;
            $display("FAIL long_release got %0d want %0d", re, SYNC + DEB);
        end
        checks++;
    endtask

    task automatic test_short();
        int np = 0, nr = 0, nl = 0;
        do_reset();
        for (int i = 0; i < 34; i++) begin
            tick({1'b0, (i < 20) ? 1'b1 : 1'b0});
            if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
                errors++;
                $display("FAIL short edge %0d got a=%h b=%h want %h", edge_n, obs_a, obs_b, exp_v);
            end
            checks++;
            np += int'(prs_a[0]); nr += int'(rel_a[0]); nl += int'(lng_a[0] | lng_b[0]);
        end
        if (np != 1 || nr != 1 || nl != 0) begin
            errors++;
            $display("FAIL short_strobes got press %0d rel %0d long %0d want 1 1 0", np, nr, nl);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int pe = -1;
        do_reset();
        for (int i = 0; i < 7; i++) tick(2'b01);
        rst = 1'b1; #1;
        if ({lvl_a, prs_a, rel_a, lng_a, lvl_b, prs_b, rel_b, lng_b} !== '0) begin
            errors++;
            $display("FAIL reset_mid_deb got nonzero outputs want 0");
        end
        checks++;
        do_reset();
        for (int i = 0; i < 45; i++) tick(2'b11);
        if ({lvl_a, lvl_b} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_mid_pre got level %b%b want 1111", lvl_a, lvl_b);
        end
        checks++;
        rst = 1'b1; #1;
        if ({lvl_a, prs_a, rel_a, lng_a, lvl_b, prs_b, rel_b, lng_b} !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold got a=%h b=%h want 0", {lvl_a, prs_a, rel_a, lng_a},
                     {lvl_b, prs_b, rel_b, lng_b});
        end
        checks++;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(2'b11);
            if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
                errors++;
                $display("FAIL reset_mid_after edge %0d got a=%h b=%h want %h", edge_n, obs_a, obs_b, exp_v);
            end
            checks++;
            if (prs_a[0] && prs_b[0]) pe = edge_n;
        end
        if (pe != SYNC + DEB) begin
            errors++;
            $display("FAIL reset_mid_press got %0d want %0d", pe, SYNC + DEB);
        end
        checks++;
    endtask

    task automatic test_active_low();
        int pe = -1, ns = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(2'b00);
            ns += int'(|{lvl_b, prs_b, rel_b, lng_b});
        end
        if (ns != 0) begin
            errors++;
            $display("FAIL al_idle got %0d active cycles want 0", ns);
        end
        checks++;
        for (int i = 1; i <= 12; i++) begin
            tick(2'b01);
            if (prs_b[0]) pe = i;
        end
        if (pe != SYNC + DEB || lvl_b !== 2'b01) begin
            errors++;
            $display("FAIL al_press got edge %0d level %b want edge %0d level 01", pe, lvl_b, SYNC + DEB);
        end
        checks++;
    endtask

    task automatic test_random();
        int rem[NB];
        logic [NB-1:0] r = '0;
        do_reset();
        for (int c = 0; c < NB; c++) rem[c] = $urandom_range(1, 45);
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NB; c++) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    r[c] = ~r[c];
                    rem[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : $urandom_range(8, 50);
                end
            end
            tick(r);
            if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
                errors++;
                $display("FAIL random edge %0d got a=%h b=%h want %h", edge_n, obs_a, obs_b, exp_v);
            end
            checks++;
        end
    endtask

    initial begin
        model_init();
        test_reset();
        test_press();
        test_bounce();
        test_long();
        test_short();
        test_reset_mid();
        test_active_low();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
